// File: rtl/ps2_keys.sv
// ps2_keys: PS/2 keyboard receiver and key-state decoder.
// Synchronises and deglitches the raw PS/2 lines, deserialises 11-bit
// device-to-host frames, tracks E0/F0 prefixes and drives held-key levels
// for the up/down arrow keys.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous, active-high; clears all state
//   ps2_clk    - raw PS/2 clock line (asynchronous)
//   ps2_dat    - raw PS/2 data line (asynchronous)
//   up, down   - levels, high while the extended up/down arrow is held
//   scan_code  - last byte received with good framing (prefixes included)
//   code_valid - one-cycle pulse when scan_code updates
//   frame_err  - one-cycle pulse on parity, stop-bit or timeout error
//   led_out    - mirror of scan_code for the board LEDs
module ps2_keys #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000,
  parameter logic [7:0]  UP_CODE    = 8'h75,
  parameter logic [7:0]  DOWN_CODE  = 8'h72
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       up,
  output logic       down,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err,
  output logic [7:0] led_out
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_q;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tmo_cnt;
  logic          ext, brk;

  // Synchronisers idle high so reset release cannot fake a falling edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // The filtered clock follows clk_s2 only after FILTER_LEN consecutive
  // samples that differ from its current level; any agreeing sample
  // restarts the run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_q   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      filt_q <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall = filt_q & ~filt_clk;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tmo_cnt    <= '0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      up         <= 1'b0;
      down       <= 1'b0;
      scan_code  <= '0;
      led_out    <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      // A falling edge takes priority over a coincident timeout expiry.
      if (fall) begin
        tmo_cnt <= '0;
        unique case (state)
          IDLE: begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat_s2;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_s2 && (^{shreg, par})) begin
              scan_code  <= shreg;
              led_out    <= shreg;
              code_valid <= 1'b1;
              if (shreg == 8'hE0) begin
                ext <= 1'b1;
              end else if (shreg == 8'hF0) begin
                brk <= 1'b1;
              end else begin
                if (ext && shreg == UP_CODE)   up   <= ~brk;
                if (ext && shreg == DOWN_CODE) down <= ~brk;
                ext <= 1'b0;
                brk <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        ext       <= 1'b0;
        brk       <= 1'b0;
        tmo_cnt   <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_keys.sv
// tb_ps2_keys: directed self-checking bench for ps2_keys.
// PS/2 frames are driven with a short bit period and a reduced TIMEOUT so the
// whole run stays short; the behaviour exercised is the same.
module tb_ps2_keys;

  localparam int unsigned HALF = 40;    // PS/2 half period in clock cycles
  localparam int unsigned TMO  = 2000;

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       up, down;
  logic [7:0] scan_code;
  logic       code_valid, frame_err;
  logic [7:0] led_out;

  int tests = 0;
  int fails = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;
  int cv0, fe0;
  logic cv_q = 1'b0, fe_q = 1'b0;
  logic pulse_bad = 1'b0;

  ps2_keys #(
    .FILTER_LEN(8),
    .TIMEOUT   (TMO),
    .UP_CODE   (8'h75),
    .DOWN_CODE (8'h72)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .up        (up),
    .down      (down),
    .scan_code (scan_code),
    .code_valid(code_valid),
    .frame_err (frame_err),
    .led_out   (led_out)
  );

  always #5 clock = ~clock;

  // Pulse monitor: counts pulses and flags overlap, width > 1 or LED skew.
  always @(negedge clock) begin
    if (!reset) begin
      if (code_valid) cv_cnt++;
      if (frame_err) fe_cnt++;
      if ((code_valid && frame_err) || (code_valid && cv_q) || (frame_err && fe_q))
        pulse_bad = 1'b1;
      if (code_valid && (led_out !== scan_code)) pulse_bad = 1'b1;
    end
    cv_q = code_valid;
    fe_q = frame_err;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b, input logic bad);
    logic p;
    p = (~^b) ^ bad;
    return {1'b1, p, b, 1'b0};
  endfunction

  // Drive the first n bits of a frame, LSB (start bit) first.
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = f[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
    cyc(HALF);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad);
    send_bits(mkframe(b, bad), 11);
    ps2_dat = 1'b1;
    cyc(20);
  endtask

  initial begin
    reset = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    cyc(5);
    check("rst_up", up, 0);
    check("rst_down", down, 0);
    check("rst_scan", scan_code, 0);
    check("rst_led", led_out, 0);
    check("rst_cv", code_valid, 0);
    check("rst_fe", frame_err, 0);
    reset = 1'b0;
    cyc(20);

    // E0 75: up pressed
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'hE0, 1'b0);
    check("e0_scan", scan_code, 8'hE0);
    check("e0_up", up, 0);
    send_frame(8'h75, 1'b0);
    check("up_cv", cv_cnt - cv0, 2);
    check("up_scan", scan_code, 8'h75);
    check("up_led", led_out, 8'h75);
    check("up_up", up, 1);
    check("up_down", down, 0);
    check("up_fe", fe_cnt - fe0, 0);

    // E0 F0 75: up released
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    check("f0_scan", scan_code, 8'hF0);
    check("f0_up_held", up, 1);
    send_frame(8'h75, 1'b0);
    check("rel_up", up, 0);
    check("rel_cv", cv_cnt - cv0, 5);

    // E0 then 72 with bad parity: error, prefix dropped, nothing else moves
    send_frame(8'hE0, 1'b0);
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h72, 1'b1);
    check("par_fe", fe_cnt - fe0, 1);
    check("par_cv", cv_cnt - cv0, 0);
    check("par_scan", scan_code, 8'hE0);
    check("par_down", down, 0);
    // ext was cleared by the error, so a plain 72 is keypad and ignored
    send_frame(8'h72, 1'b0);
    check("kp72_scan", scan_code, 8'h72);
    check("kp72_down", down, 0);

    // Non-extended 75
    cv0 = cv_cnt;
    send_frame(8'h75, 1'b0);
    check("kp75_cv", cv_cnt - cv0, 1);
    check("kp75_scan", scan_code, 8'h75);
    check("kp75_up", up, 0);

    // Partial frame then idle: timeout error TMO cycles after last edge
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_bits(mkframe(8'h55, 1'b0), 5);
    ps2_dat = 1'b1;
    cyc(TMO - 200);
    check("tmo_early", fe_cnt - fe0, 0);
    cyc(400);
    check("tmo_fe", fe_cnt - fe0, 1);
    check("tmo_cv", cv_cnt - cv0, 0);
    cyc(200);
    send_frame(8'h1C, 1'b0);
    check("tmo_next_scan", scan_code, 8'h1C);
    check("tmo_next_cv", cv_cnt - cv0, 1);
    check("tmo_next_fe", fe_cnt - fe0, 1);

    // 3-cycle low glitches with data low: must never start a frame
    cv0 = cv_cnt; fe0 = fe_cnt;
    ps2_dat = 1'b0;
    for (int g = 0; g < 6; g++) begin
      ps2_clk = 1'b0;
      cyc(3);
      ps2_clk = 1'b1;
      cyc(20);
    end
    ps2_dat = 1'b1;
    cyc(TMO + 200);
    check("glitch_fe", fe_cnt - fe0, 0);
    check("glitch_cv", cv_cnt - cv0, 0);
    send_frame(8'h29, 1'b0);
    check("glitch_next_scan", scan_code, 8'h29);
    check("glitch_next_cv", cv_cnt - cv0, 1);

    // Reset during bit 5 while up is held
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("pre_rst_up", up, 1);
    send_bits(mkframe(8'h72, 1'b0), 5);
    ps2_dat = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF / 2);
    reset = 1'b1;
    cyc(3);
    check("mid_rst_up", up, 0);
    check("mid_rst_scan", scan_code, 0);
    check("mid_rst_led", led_out, 0);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    cyc(5);
    reset = 1'b0;
    cyc(HALF);
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'hE0, 1'b0);
    send_frame(8'h72, 1'b0);
    check("post_rst_cv", cv_cnt - cv0, 2);
    check("post_rst_fe", fe_cnt - fe0, 0);
    check("post_rst_down", down, 1);
    check("post_rst_up", up, 0);
    check("post_rst_scan", scan_code, 8'h72);

    check("pulse_shape", pulse_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net: never hang.
  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_keys.md
# ps2_keys

PS/2 keyboard receiver and key-state decoder that sits directly upstream of the game logic. It synchronises and deglitches the raw PS2_CLK/PS2_DAT lines, deserialises 11-bit device-to-host frames, tracks E0/F0 prefixes, and produces held-key levels for the up/down paddle controls plus the last received scan code for the board LEDs. It runs entirely in the 50 MHz `clock` domain.

## Interface
- FILTER_LEN, 8: consecutive equal synchronised samples required before the filtered PS/2 clock changes level (2..255).
- TIMEOUT, 50000: `clock` cycles without a filtered falling edge that abort a partial frame (1 ms at 50 MHz).
- UP_CODE, 8'h75: extended scan code for the up key (E0 75, arrow up).
- DOWN_CODE, 8'h72: extended scan code for the down key (E0 72, arrow down).
- clock  in  1  50 MHz system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous.
- ps2_dat  in  1  raw PS/2 data line, asynchronous.
- up  out  1  level, 1 while the up key is held.
- down  out  1  level, 1 while the down key is held.
- scan_code  out  8  last byte received with good framing, prefixes included.
- code_valid  out  1  one-cycle pulse when scan_code updates.
- frame_err  out  1  one-cycle pulse on a parity, stop-bit or timeout error.
- led_out  out  8  mirrors scan_code for the board LEDs.

## Operation
- Input conditioning: both lines pass through 2-flop synchronisers. The filtered clock (reset value 1) takes the synchronised level only after FILTER_LEN consecutive identical samples. A falling edge is the cycle in which the filtered clock goes 1->0. Data is sampled from the synchronised ps2_dat on that cycle.
- Frame FSM (reset IDLE):
  - IDLE: on a falling edge, data 0 -> DATA with bit count 0. Data 1 is a spurious start bit: stay in IDLE, no error.
  - DATA: shift the bit in LSB first. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: on the falling edge, accept the frame if the stop bit is 1 and the 8 data bits plus the parity bit have odd parity. Otherwise pulse frame_err. Always -> IDLE.
- Timeout: a cycle counter clears on every falling edge and while in IDLE. If it reaches TIMEOUT outside IDLE, the FSM goes to IDLE, frame_err pulses and the prefix flags clear.
- Decoder, on each accepted byte B (scan_code <= B, code_valid pulses):
  - B = E0: set the ext flag.
  - B = F0: set the brk flag.
  - Any other B: if ext and B = UP_CODE, up <= ~brk; if ext and B = DOWN_CODE, down <= ~brk. Then clear ext and brk.
  - Non-extended 75/72 (keypad) never changes up or down.
- A frame error clears ext and brk and leaves up, down and scan_code unchanged.
- Reset values: FSM IDLE, up = 0, down = 0, scan_code = 0, led_out = 0, code_valid = 0, frame_err = 0, ext = 0, brk = 0, filtered clock = 1.

## Timing
- Falling-edge detect latency: 2 synchroniser cycles + FILTER_LEN cycles after the raw ps2_clk fall.
- scan_code, led_out, code_valid, up and down all update in the first cycle after the falling-edge cycle that samples the stop bit. frame_err is asserted in that same cycle.
- A falling edge and a timeout expiry in the same cycle: the edge wins and the timeout counter clears.
- Reset asserted mid-frame discards the partial frame immediately. After reset releases, the next start bit begins a clean frame.
- code_valid and frame_err are never high in the same cycle. Each is exactly one cycle wide.
- Minimum spacing between code_valid pulses is one PS/2 frame. No internal buffering; bytes are never dropped or queued.

## Test plan
- Frame E0, then 75, each with correct odd parity, at a 12.5 kHz PS/2 clock -> two code_valid pulses; scan_code = 8'h75; up = 1, down = 0. Then E0 F0 75 -> up = 0.
- Frame 8'h72 with parity bit inverted -> frame_err pulses once, no code_valid, scan_code keeps its previous value, down unchanged.
- Non-extended 75 -> code_valid pulses, scan_code = 8'h75, up stays 0.
- Send start + 4 data bits, then hold ps2_clk high for 60000 cycles -> frame_err pulses at cycle 50000; the next full frame 8'h1C decodes with scan_code = 8'h1C.
- 3-cycle low glitches on ps2_clk with FILTER_LEN = 8 -> no falling edge, FSM stays IDLE, no pulses.
- Assert reset during bit 5 of a frame while up = 1 -> up = 0, scan_code = 0. The following E0 72 frames give down = 1.
